// File: rtl/interconnect_arb.sv
// N-to-1 packet merge: fixed-priority or round-robin arbitration in front of an output FIFO.
// Each buffered packet is tagged with the index of the source it came from.
module interconnect_arb #(
   parameter int unsigned DATA_WIDTH  = 192,
   parameter int unsigned CONNECT_NUM = 3,
   parameter int unsigned ID_WIDTH    = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ARB_MODE    = 0
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
   output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
   input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
   output logic                              SEND_VALID,
   input  logic                              SEND_READY,
   output logic [DATA_WIDTH-1:0]             SEND_DATA,
   output logic [ID_WIDTH-1:0]               SEND_ID,
   output logic [$clog2(FIFO_DEPTH):0]       FILL_LEVEL
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [ID_WIDTH-1:0]   mem_id   [FIFO_DEPTH];

   logic [ID_WIDTH-1:0]    win;
   logic                   found;
   logic [CONNECT_NUM-1:0] grant_c;
   logic                   push;
   logic                   pop;
   logic [DATA_WIDTH-1:0]  win_data;

   // Winner selection: highest requester, or first requester at/after rr_ptr
   always_comb begin
      int unsigned idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      if (ARB_MODE == 0) begin
         for (int unsigned i = 0; i < CONNECT_NUM; i++) begin
            if (RECEIVE_VALID[i]) begin
               win   = ID_WIDTH'(i);
               found = 1'b1;
            end
         end
      end else begin
         for (int unsigned k = 0; k < CONNECT_NUM; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= CONNECT_NUM) idx = idx - CONNECT_NUM;
            if (!found && RECEIVE_VALID[idx]) begin
               win   = ID_WIDTH'(idx);
               found = 1'b1;
            end
         end
      end
   end

   // Grant is held off while in reset so no handshake can land on a reset edge
   always_comb begin
      grant_c = '0;
      if (RST && found && (count < CNT_W'(FIFO_DEPTH))) grant_c[win] = 1'b1;
   end

   assign RECEIVE_READY = grant_c;
   assign push          = |grant_c;
   assign pop           = (count != '0) && SEND_READY;
   assign win_data      = RECEIVE_DATA[DATA_WIDTH*32'(win) +: DATA_WIDTH];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rr_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            rr_ptr <= (32'(win) == CONNECT_NUM - 1) ? '0 : win + ID_WIDTH'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Packet storage carries no reset; contents are only observed when count says so
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_data[wr_ptr] <= win_data;
         mem_id[wr_ptr]   <= win;
      end
   end

   assign SEND_VALID = (count != '0);
   assign SEND_DATA  = mem_data[rd_ptr];
   assign SEND_ID    = mem_id[rd_ptr];
   assign FILL_LEVEL = count;

endmodule
